// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter
//  Purpose  : Shares one single-port, variable-latency unified memory between
//             the instruction-fetch and load/store stages. One requester is
//             granted at a time, the request is held until mem_ack, and the
//             winner receives a one-cycle ready pulse with its read data.
//  Revision : 1.0  initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // load/store side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  // pipeline freeze
  output logic              stall_if,
  output logic              stall_mem,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // sticky timeout flag
  output logic              bus_err
);

  localparam int              RUN_W   = 4;
  localparam int              TO_W    = $clog2(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT - 1);
  // Instruction fetches are always full-word reads.
  localparam logic [2:0]       FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]          mem_funct3_q, mem_funct3_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                bus_err_q, bus_err_d;

  // Arbitration terms: the IF side only wins a contended slot once the data run is exhausted.
  logic run_full;
  logic if_eligible;
  logic grant_d;
  logic grant_i;
  logic in_grant;
  logic timed_out;
  logic xfer_done;
  logic [DATA_W-1:0] xfer_data;

  assign run_full    = (run_cnt_q == RUN_MAX);
  assign if_eligible = if_req & ~if_flush;
  assign grant_d     = dm_req & ~(if_eligible & run_full);
  assign grant_i     = if_eligible & (~dm_req | run_full);
  assign in_grant    = (state_q != S_IDLE);
  // mem_ack takes priority over an expiring timeout in the same cycle.
  assign timed_out   = in_grant & ~mem_ack & (to_cnt_q == TO_MAX);
  assign xfer_done   = in_grant & (mem_ack | timed_out);
  assign xfer_data   = mem_ack ? mem_rdata : '0;

  // Next-state, request latching and completion logic.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    to_cnt_d     = to_cnt_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    bus_err_d    = bus_err_q;

    // A data run only counts while a fetch is actually being held off.
    if (!if_req) begin
      run_cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        to_cnt_d     = '0;
        flush_pend_d = 1'b0;
        if (grant_d) begin
          state_d      = S_GRANT_D;
          mem_req_d    = 1'b1;
          mem_we_d     = dm_we;
          mem_addr_d   = dm_addr;
          mem_wdata_d  = dm_wdata;
          mem_funct3_d = dm_funct3;
          if (if_req && !run_full) begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d      = S_GRANT_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          mem_funct3_d = FETCH_FUNCT3;
          run_cnt_d    = '0;
        end
      end

      S_GRANT_I, S_GRANT_D: begin
        if ((state_q == S_GRANT_I) && if_flush) begin
          flush_pend_d = 1'b1;
        end
        if (xfer_done) begin
          state_d      = S_IDLE;
          mem_req_d    = 1'b0;
          to_cnt_d     = '0;
          flush_pend_d = 1'b0;
          if (timed_out) begin
            bus_err_d = 1'b1;
          end
          if (state_q == S_GRANT_I) begin
            // A flushed fetch still finishes on the bus but is never delivered.
            if (!(flush_pend_q || if_flush)) begin
              if_ready_d = 1'b1;
              if_rdata_d = xfer_data;
            end
          end else begin
            dm_ready_d = 1'b1;
            dm_rdata_d = mem_we_q ? '0 : xfer_data;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      run_cnt_q    <= '0;
      to_cnt_q     <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      to_cnt_q     <= to_cnt_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // A flush arriving in the very cycle of the fetch pulse still cancels the delivery.
  assign if_ready   = if_ready_q & ~if_flush;
  assign dm_ready   = dm_ready_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign stall_if   = if_req & ~if_ready;
  assign stall_mem  = dm_req & ~dm_ready;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = mem_funct3_q;
  assign bus_err    = bus_err_q;

endmodule
`default_nettype wire
